// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR coefficient loader and coefficient mux wiring.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAD,
    ARMED,
    SYNC
  } fir_state_t;

  function automatic int max1_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // LSB position of coefficient k inside a flat packed coefficient bus
  function automatic int coef_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// N x W coefficient register bank with a single write port and a flat read-out.
// Latency: a write is visible on flat the cycle after the enabling edge.
// Backpressure: none; out-of-range indices are ignored.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 18,
  parameter int IDXW = 3
) (
  input  logic           fir_clk,
  input  logic           fir_rst,
  input  logic           en,
  input  logic [IDXW-1:0] idx,
  input  logic [W-1:0]   data,
  output logic [N*W-1:0] flat
);

  logic [W-1:0] mem [N];

  always_ff @(posedge fir_clk or posedge fir_rst) begin
    if (fir_rst) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else if (en && (int'(idx) < N)) begin
      mem[idx] <= data;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign flat[coef_lsb(k, W) +: W] = mem[k];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient controller: shadow writes, zero-pad, frame-aligned swap, resync.
// Latency: commit-to-swap = 1 + (N-n) pad cycles + frame alignment; then N resync cycles.
// Backpressure: wr_ready low and commits dropped (commit_drop pulse) whenever not IDLE.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int FIR_COEF_WIDTH = 18,
  parameter int FIR_DSP_NR     = 4,
  parameter int FIR_TM         = 2,
  parameter int COUNT_WIDTH    = max1_clog2(FIR_TM),
  parameter int IDXW           = max1_clog2(FIR_TM * FIR_DSP_NR)
) (
  input  logic                                     fir_clk,
  input  logic                                     fir_rst,
  input  logic [COUNT_WIDTH-1:0]                   count_in,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [IDXW-1:0]                          wr_idx,
  input  logic [FIR_COEF_WIDTH-1:0]                wr_data,
  input  logic                                     commit,
  input  logic [31:0]                              n_active,
  output logic [FIR_TM*FIR_DSP_NR*FIR_COEF_WIDTH-1:0] coefs_flat,
  output logic                                     bank_sel,
  output logic                                     busy,
  output logic                                     commit_drop
);

  localparam int N = FIR_TM * FIR_DSP_NR;
  localparam int W = FIR_COEF_WIDTH;
  localparam logic [IDXW:0]        N_P      = (IDXW + 1)'(N);
  localparam logic [IDXW:0]        LAST_P   = (IDXW + 1)'(N - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(FIR_TM - 1);

  fir_state_t       state, state_nxt;
  logic [IDXW:0]    ptr, ptr_nxt;
  logic             bank_sel_q, bank_sel_nxt;
  logic             drop_q;
  logic [IDXW:0]    n_clamp;
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [W-1:0]     wr_val;
  logic [N*W-1:0]   flat_a, flat_b, active_flat;
  logic [W-1:0]     active_coef;

  assign n_clamp     = (n_active > 32'(N)) ? N_P : n_active[IDXW:0];
  assign active_flat = bank_sel_q ? flat_b : flat_a;
  assign active_coef = active_flat[coef_lsb(int'(ptr[IDXW-1:0]), W) +: W];

  always_ff @(posedge fir_clk or posedge fir_rst) begin
    if (fir_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      bank_sel_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      bank_sel_q <= bank_sel_nxt;
      drop_q     <= commit && (state != IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    bank_sel_nxt = bank_sel_q;
    wr_en        = 1'b0;
    wr_addr      = wr_idx;
    wr_val       = wr_data;
    case (state)
      IDLE: begin
        // a write in the commit cycle lands first, so it is part of the committed set
        wr_en = wr_valid && ({1'b0, wr_idx} < N_P);
        if (commit) begin
          ptr_nxt   = n_clamp;
          state_nxt = (n_clamp < N_P) ? PAD : ARMED;
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_addr = ptr[IDXW-1:0];
        wr_val  = '0;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_P) state_nxt = ARMED;
      end
      ARMED: begin
        if (count_in == CNT_LAST) begin
          bank_sel_nxt = ~bank_sel_q;
          ptr_nxt      = '0;
          state_nxt    = SYNC;
        end
      end
      SYNC: begin
        // bank_sel already points at the new set; refresh the old bank from it
        wr_en   = 1'b1;
        wr_addr = ptr[IDXW-1:0];
        wr_val  = active_coef;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_P) begin
          ptr_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  fir_coef_bank #(.N(N), .W(W), .IDXW(IDXW)) u_bank_a (
    .fir_clk (fir_clk),
    .fir_rst (fir_rst),
    .en      (wr_en && bank_sel_q),
    .idx     (wr_addr),
    .data    (wr_val),
    .flat    (flat_a)
  );

  fir_coef_bank #(.N(N), .W(W), .IDXW(IDXW)) u_bank_b (
    .fir_clk (fir_clk),
    .fir_rst (fir_rst),
    .en      (wr_en && !bank_sel_q),
    .idx     (wr_addr),
    .data    (wr_val),
    .flat    (flat_b)
  );

  assign coefs_flat  = active_flat;
  assign bank_sel    = bank_sel_q;
  assign busy        = (state != IDLE);
  assign wr_ready    = (state == IDLE);
  assign commit_drop = drop_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: directed vector table, busy/reset sequences, random traffic vs model.
// Latency: n/a. Backpressure: n/a.
// The model tracks banks as plain arrays and derives swap/idle edges arithmetically from commit time.
module tb_fir_coef_loader;

  localparam int N  = 8;
  localparam int W  = 18;
  localparam int TM = 2;

  typedef logic [W-1:0] set_t [N];

  typedef struct {
    int          mode;   // 0: idx+1 everywhere, 1: fill eval, 2: single edit, 3: edit in commit cycle
    int          eidx;
    logic [W-1:0] eval;
    logic [31:0] nact;
    int          pad;
    logic [N*W-1:0] exp;
  } vec_t;

  logic           fir_clk = 1'b0;
  logic           fir_rst;
  logic [0:0]     count_in;
  logic           wr_valid;
  logic           wr_ready;
  logic [2:0]     wr_idx;
  logic [W-1:0]   wr_data;
  logic           commit;
  logic [31:0]    n_active;
  logic [N*W-1:0] coefs_flat;
  logic           bank_sel;
  logic           busy;
  logic           commit_drop;

  always #5 fir_clk = ~fir_clk;

  fir_coef_loader #(.FIR_COEF_WIDTH(W), .FIR_DSP_NR(4), .FIR_TM(TM)) dut (
    .fir_clk     (fir_clk),
    .fir_rst     (fir_rst),
    .count_in    (count_in),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .commit      (commit),
    .n_active    (n_active),
    .coefs_flat  (coefs_flat),
    .bank_sel    (bank_sel),
    .busy        (busy),
    .commit_drop (commit_drop)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   swaps = 0;
  set_t shd, act, pend;
  bit   m_sel, m_busy;
  int   swap_edge, end_edge;

  task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input set_t s);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = s[k];
    return r;
  endfunction

  function automatic logic [N*W-1:0] mk8(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [0:0] next_cnt(input logic [0:0] c);
    return (int'(c) == TM - 1) ? 1'b0 : c + 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      shd[k] = '0;
      act[k] = '0;
      pend[k] = '0;
    end
    m_sel  = 1'b0;
    m_busy = 1'b0;
  endtask

  // One clock: advance the model over the coming edge, then compare every output
  task automatic tick();
    int j, n, c, d;
    bit drop_e;
    logic prev_sel;
    j = cyc + 1;
    drop_e = commit && m_busy;
    if (!m_busy) begin
      if (wr_valid && int'(wr_idx) < N) shd[wr_idx] = wr_data;
      if (commit) begin
        n = (n_active > N) ? N : int'(n_active);
        for (int k = 0; k < N; k++) pend[k] = (k < n) ? shd[k] : '0;
        c = (int'(count_in) + (N - n) + 1) % TM;
        d = (TM - 1 - c + TM) % TM;
        swap_edge = j + (N - n) + 1 + d;
        end_edge  = swap_edge + N;
        m_busy = 1'b1;
      end
    end
    if (m_busy && j == swap_edge) begin
      act = pend;
      shd = pend;
      m_sel = !m_sel;
    end
    if (m_busy && j == end_edge) m_busy = 1'b0;
    prev_sel = bank_sel;
    @(posedge fir_clk);
    #1;
    cyc = j;
    count_in = next_cnt(count_in);
    if (bank_sel !== prev_sel) swaps++;
    chk("busy", busy, m_busy);
    chk("wr_ready", wr_ready, !m_busy);
    chk("bank_sel", bank_sel, m_sel);
    chk("commit_drop", commit_drop, drop_e);
    chk("coefs_flat", coefs_flat, pack(act));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && m_busy; i++) tick();
  endtask

  task automatic write1(input int idx, input logic [W-1:0] val);
    wr_valid = 1'b1;
    wr_idx   = 3'(idx);
    wr_data  = val;
    tick();
    wr_valid = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    int c0, cnt0, d, t, s, sw0;
    logic s0;

    vecs[0] = '{mode: 0, eidx: 0, eval: 18'h0,     nact: 32'd8,   pad: 0,
                exp: mk8(18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8)};
    vecs[1] = '{mode: 1, eidx: 0, eval: 18'h1FFFF, nact: 32'd3,   pad: 5,
                exp: mk8(18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0)};
    vecs[2] = '{mode: 2, eidx: 1, eval: 18'd5,     nact: 32'd8,   pad: 0,
                exp: mk8(18'h1FFFF, 18'd5, 18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0)};
    vecs[3] = '{mode: 2, eidx: 7, eval: 18'h2A,    nact: 32'd100, pad: 0,
                exp: mk8(18'h1FFFF, 18'd5, 18'h1FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 18'h2A)};
    vecs[4] = '{mode: 3, eidx: 2, eval: 18'd7,     nact: 32'd8,   pad: 0,
                exp: mk8(18'h1FFFF, 18'd5, 18'd7, 18'd0, 18'd0, 18'd0, 18'd0, 18'h2A)};

    fir_rst  = 1'b1;
    count_in = '0;
    wr_valid = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    commit   = 1'b0;
    n_active = '0;
    model_reset();
    repeat (2) begin
      @(posedge fir_clk);
      #1;
      cyc++;
      count_in = next_cnt(count_in);
    end
    chk("rst_busy", busy, 1'b0);
    chk("rst_bank_sel", bank_sel, 1'b0);
    chk("rst_coefs", coefs_flat, '0);
    chk("rst_drop", commit_drop, 1'b0);
    fir_rst = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 1'b1);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      case (vecs[v].mode)
        0: for (int i = 0; i < N; i++) write1(i, 18'(i + 1));
        1: for (int i = 0; i < N; i++) write1(i, vecs[v].eval);
        2: write1(vecs[v].eidx, vecs[v].eval);
        default: ;
      endcase
      c0   = cyc;
      cnt0 = int'(count_in);
      s0   = bank_sel;
      commit   = 1'b1;
      n_active = vecs[v].nact;
      if (vecs[v].mode == 3) begin
        wr_valid = 1'b1;
        wr_idx   = 3'(vecs[v].eidx);
        wr_data  = vecs[v].eval;
      end
      tick();
      commit   = 1'b0;
      wr_valid = 1'b0;
      for (t = 0; t < 64 && bank_sel === s0; t++) tick();
      checks++;
      if (t == 64) begin
        errors++;
        $display("FAIL swap_timeout vec %0d got=no_swap expected=swap", v);
      end
      d = (TM - 1 - ((cnt0 + vecs[v].pad + 1) % TM) + TM) % TM;
      chk($sformatf("latency_v%0d", v), 32'(cyc - c0), 32'(2 + vecs[v].pad + d));
      chk($sformatf("active_v%0d", v), coefs_flat, vecs[v].exp);
      chk($sformatf("swap_frame_v%0d", v), count_in, 1'b0);
      s = cyc;
      for (t = 0; t < 64 && busy === 1'b1; t++) tick();
      chk($sformatf("sync_len_v%0d", v), 32'(cyc - s), 32'(N));
    end

    // Commit and writes while busy are rejected; held write lands once IDLE
    wait_idle();
    sw0 = swaps;
    commit   = 1'b1;
    n_active = 32'd8;
    tick();
    wr_valid = 1'b1;
    wr_idx   = 3'd4;
    wr_data  = 18'h44;
    tick();
    commit = 1'b0;
    chk("busy_reject_wr_ready", wr_ready, 1'b0);
    for (int i = 0; i < 64 && m_busy; i++) tick();
    tick();
    wr_valid = 1'b0;
    chk("single_swap", 32'(swaps - sw0), 32'd1);
    commit   = 1'b1;
    n_active = 32'd8;
    tick();
    commit = 1'b0;
    wait_idle();
    chk("held_write", coefs_flat[4*W +: W], 18'h44);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_idx   = 3'($urandom);
      wr_data  = 18'($urandom);
      commit   = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: n_active = 32'($urandom_range(0, 7));
        1: n_active = 32'd8;
        2: n_active = 32'($urandom_range(9, 200));
        default: n_active = 32'hFFFF_FFFF;
      endcase
      tick();
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    wait_idle();

    // Reset in the middle of SYNC
    commit   = 1'b1;
    n_active = 32'd8;
    s0 = bank_sel;
    tick();
    commit = 1'b0;
    for (t = 0; t < 64 && bank_sel === s0; t++) tick();
    tick();
    tick();
    chk("pre_reset_busy", busy, 1'b1);
    fir_rst = 1'b1;
    #2;
    model_reset();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_bank_sel", bank_sel, 1'b0);
    chk("midrst_coefs", coefs_flat, '0);
    chk("midrst_drop", commit_drop, 1'b0);
    @(posedge fir_clk);
    #1;
    cyc++;
    count_in = next_cnt(count_in);
    fir_rst = 1'b0;
    #1;
    chk("postrst_wr_ready", wr_ready, 1'b1);
    write1(0, 18'h123);
    commit   = 1'b1;
    n_active = 32'd1;
    tick();
    commit = 1'b0;
    wait_idle();
    chk("postrst_commit", coefs_flat, mk8(18'h123, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
